// File: rtl/reg_file_sb_if.sv
// Bundle between issue/writeback logic and the scoreboarded register file.
// master = pipeline side (drives reads, issues, writebacks); slave = register file.
interface reg_file_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     iss_valid;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     iss_ready;
   logic                     wb_valid;
   logic [ADDR_W-1:0]        wb_addr;
   logic [DATA_W-1:0]        wb_data;
   logic                     flush;
   logic [ADDR_W:0]          busy_cnt;
   logic                     sb_err;

   modport master (
      output rd_addr, iss_valid, iss_addr,
      output wb_valid, wb_addr, wb_data, flush,
      input  rd_data, rd_busy, iss_ready,
      input  busy_cnt, sb_err
   );

   modport slave (
      input  rd_addr, iss_valid, iss_addr,
      input  wb_valid, wb_addr, wb_data, flush,
      output rd_data, rd_busy, iss_ready,
      output busy_cnt, sb_err
   );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD combinational read ports, one writeback port and a
// per-register busy scoreboard (reserve at issue, release at writeback).
// Ports: clk, rst (async active-low), bus (reg_file_sb_if.slave): rd_addr/rd_data/
// rd_busy reads, iss_valid/iss_addr/iss_ready reservation handshake,
// wb_valid/wb_addr/wb_data writeback, flush, busy_cnt, sb_err.
// Option: define RF_BYPASS_EN to forward writeback data/busy=0 to same-cycle reads.
module reg_file_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic        clk,
   input  logic        rst,
   reg_file_sb_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int CW    = ADDR_W + 1;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;

   logic              wr_en;
   logic              iss_ok;
   logic              set;
   logic              clr;

   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;

   // busy_q[0] is held at 0, so r0 is always issuable and never flagged
   assign iss_ok = bus.iss_valid & ~busy_q[bus.iss_addr] & ~bus.flush;
   assign wr_en  = bus.wb_valid & (bus.wb_addr != '0);
   assign set    = iss_ok & (bus.iss_addr != '0);
   assign clr    = wr_en & busy_q[bus.wb_addr];
   // sb_err uses the pre-flush busy bit
   assign err_d  = wr_en & ~busy_q[bus.wb_addr];

   // set and clr can never target the same register: set needs it idle,
   // clr needs it busy
   always_comb begin
      busy_d = busy_q;
      if (clr)
         busy_d[bus.wb_addr] = 1'b0;
      if (set)
         busy_d[bus.iss_addr] = 1'b1;
      if (bus.flush)
         busy_d = '0;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      if (bus.flush)
         cnt_d = '0;
      else
         cnt_d = cnt_q + CW'(set) - CW'(clr);
   end

   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_data_c[p*DATA_W +: DATA_W] =
            regs_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
         rd_busy_c[p] = busy_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
         if (wr_en && bus.wb_addr == bus.rd_addr[p*ADDR_W +: ADDR_W]) begin
            rd_data_c[p*DATA_W +: DATA_W] = bus.wb_data;
            rd_busy_c[p] = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            regs_q[i] <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (wr_en)
            regs_q[bus.wb_addr] <= bus.wb_data;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign bus.rd_data   = rd_data_c;
   assign bus.rd_busy   = rd_busy_c;
   assign bus.iss_ready = iss_ok;
   assign bus.busy_cnt  = cnt_q;
   assign bus.sb_err    = err_q;

   a_cnt_pop: assert property (@(posedge clk) disable iff (!rst)
      cnt_q == CW'($countones(busy_q)));
   a_cnt_max: assert property (@(posedge clk) disable iff (!rst)
      cnt_q <= CW'(DEPTH - 1));
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb.
// One task per scenario; expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_reg_file_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.iss_valid = 1'b0;
      bus.iss_addr  = '0;
      bus.wb_valid  = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;
      bus.flush     = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      bus.rd_addr = '0;
      rst = 1'b0;
      #12;
      rst = 1'b1;
      tick();
      n_chk++;
      if (bus.busy_cnt !== 6'd0 || bus.sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cnt_err: got cnt=%0d err=%b want 0 0",
                  bus.busy_cnt, bus.sb_err);
      end
      for (int a = 0; a < 32; a++) begin
         bus.rd_addr = {AW'(a), AW'(a)};
         #0.1;
         n_chk++;
         if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_read r%0d: got %h busy %b want 0 00",
                     a, bus.rd_data, bus.rd_busy);
         end
      end
   endtask

   task automatic test_issue_wb();
      bus.rd_addr = {5'd0, 5'd5};
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd5;
      #1;
      n_chk++;
      if (bus.iss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL iss_first: got %b want 1", bus.iss_ready);
      end
      tick();
      n_chk++;
      if (bus.iss_ready !== 1'b0 || bus.busy_cnt !== 6'd1
          || bus.rd_busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL iss_second: got rdy=%b cnt=%0d busy=%b want 0 1 1",
                  bus.iss_ready, bus.busy_cnt, bus.rd_busy[0]);
      end
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd5;
      bus.wb_data  = 32'hDEADBEEF;
      #1;
      n_chk++;
      if (bus.iss_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL iss_during_wb: got %b want 0", bus.iss_ready);
      end
      tick();
      bus.wb_valid = 1'b0;
      #0.1;
      n_chk++;
      if (bus.busy_cnt !== 6'd0 || bus.rd_data[31:0] !== 32'hDEADBEEF
          || bus.sb_err !== 1'b0 || bus.iss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wb_r5: got cnt=%0d d=%h err=%b rdy=%b want 0 deadbeef 0 1",
                  bus.busy_cnt, bus.rd_data[31:0], bus.sb_err, bus.iss_ready);
      end
      tick();
      bus.iss_valid = 1'b0;
      n_chk++;
      if (bus.busy_cnt !== 6'd1) begin
         n_fail++;
         $display("FAIL reissue_r5: got cnt=%0d want 1", bus.busy_cnt);
      end
      bus.wb_valid = 1'b1;
      bus.wb_data  = 32'hDEADBEEF;
      tick();
      idle();
   endtask

   task automatic test_r0();
      bus.rd_addr   = '0;
      bus.wb_valid  = 1'b1;
      bus.wb_addr   = 5'd0;
      bus.wb_data   = 32'hFFFFFFFF;
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd0;
      #1;
      n_chk++;
      if (bus.iss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL r0_iss: got %b want 1", bus.iss_ready);
      end
      tick();
      idle();
      #0.1;
      n_chk++;
      if (bus.rd_data[31:0] !== 32'd0 || bus.busy_cnt !== 6'd0
          || bus.sb_err !== 1'b0 || bus.rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL r0_state: got d=%h cnt=%0d err=%b busy=%b want 0 0 0 0",
                  bus.rd_data[31:0], bus.busy_cnt, bus.sb_err, bus.rd_busy[0]);
      end
   endtask

   task automatic test_sb_err();
      bus.rd_addr  = {5'd0, 5'd7};
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd7;
      bus.wb_data  = 32'h12345678;
      tick();
      idle();
      #0.1;
      n_chk++;
      if (bus.sb_err !== 1'b1 || bus.rd_data[31:0] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL sb_err_set: got err=%b d=%h want 1 12345678",
                  bus.sb_err, bus.rd_data[31:0]);
      end
      tick();
      n_chk++;
      if (bus.sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_err_pulse: got %b want 0", bus.sb_err);
      end
   endtask

   task automatic test_flush_bypass();
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd1;
      tick();
      bus.iss_addr  = 5'd2;
      tick();
      bus.iss_addr  = 5'd3;
      tick();
      n_chk++;
      if (bus.busy_cnt !== 6'd3) begin
         n_fail++;
         $display("FAIL flush_pre: got cnt=%0d want 3", bus.busy_cnt);
      end
      bus.iss_addr = 5'd4;
      bus.flush    = 1'b1;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd2;
      bus.wb_data  = 32'hA5A5A5A5;
      #1;
      n_chk++;
      if (bus.iss_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_iss: got %b want 0", bus.iss_ready);
      end
      tick();
      idle();
      bus.rd_addr = {5'd1, 5'd2};
      #0.1;
      n_chk++;
      if (bus.busy_cnt !== 6'd0 || bus.rd_data[31:0] !== 32'hA5A5A5A5
          || bus.sb_err !== 1'b0 || bus.rd_busy !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_post: got cnt=%0d d=%h err=%b busy=%b want 0 a5a5a5a5 0 00",
                  bus.busy_cnt, bus.rd_data[31:0], bus.sb_err, bus.rd_busy);
      end
      bus.rd_addr   = {5'd0, 5'd9};
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd9;
      tick();
      idle();
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd9;
      bus.wb_data  = 32'h0BADF00D;
      #1;
      n_chk++;
`ifdef RF_BYPASS_EN
      if (bus.rd_data[31:0] !== 32'h0BADF00D || bus.rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass_wb: got d=%h busy=%b want 0badf00d 0",
                  bus.rd_data[31:0], bus.rd_busy[0]);
      end
`else
      if (bus.rd_data[31:0] !== 32'd0 || bus.rd_busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL nobypass_wb: got d=%h busy=%b want 0 1",
                  bus.rd_data[31:0], bus.rd_busy[0]);
      end
`endif
      tick();
      idle();
      #0.1;
      n_chk++;
      if (bus.rd_data[31:0] !== 32'h0BADF00D || bus.rd_busy[0] !== 1'b0
          || bus.busy_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL wb_r9_after: got d=%h busy=%b cnt=%0d want 0badf00d 0 0",
                  bus.rd_data[31:0], bus.rd_busy[0], bus.busy_cnt);
      end
   endtask

   task automatic test_back_to_back();
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd10;
      tick();
      bus.iss_addr  = 5'd11;
      tick();
      bus.iss_addr  = 5'd12;
      bus.wb_valid  = 1'b1;
      bus.wb_addr   = 5'd10;
      bus.wb_data   = 32'h00C0FFEE;
      tick();
      idle();
      bus.rd_addr = {5'd12, 5'd10};
      #0.1;
      n_chk++;
      if (bus.busy_cnt !== 6'd2 || bus.rd_busy !== 2'b10
          || bus.rd_data[31:0] !== 32'h00C0FFEE || bus.sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL set_clr: got cnt=%0d busy=%b d=%h err=%b want 2 10 00c0ffee 0",
                  bus.busy_cnt, bus.rd_busy, bus.rd_data[31:0], bus.sb_err);
      end
   endtask

   task automatic test_async_reset();
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'd20;
      tick();
      bus.iss_addr  = 5'd21;
      tick();
      idle();
      n_chk++;
      if (bus.busy_cnt !== 6'd4) begin
         n_fail++;
         $display("FAIL arst_pre: got cnt=%0d want 4", bus.busy_cnt);
      end
      #1;
      rst = 1'b0;
      #1;
      n_chk++;
      if (bus.busy_cnt !== 6'd0 || bus.sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_cnt: got cnt=%0d err=%b want 0 0",
                  bus.busy_cnt, bus.sb_err);
      end
      for (int a = 0; a < 32; a++) begin
         bus.rd_addr = {AW'(a), AW'(a)};
         #0.1;
         n_chk++;
         if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_read r%0d: got %h busy %b want 0 00",
                     a, bus.rd_data, bus.rd_busy);
         end
      end
      rst = 1'b1;
      tick();
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      idle();
      bus.rd_addr = '0;
      test_reset();
      test_issue_wb();
      test_r0();
      test_sb_err();
      test_flush_bypass();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
